// File: rtl/xadc_channel_averager.sv
// rtl/xadc_channel_averager.sv - per-channel box-car averager for XADC DRP reads
// Results queue in a show-ahead FIFO; completions that find it full are counted and dropped.
module xadc_channel_averager #(
  parameter int LOG2_N     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK100MHZ,
  input  logic        ck_rst,
  input  logic        s_drdy,
  input  logic [6:0]  s_daddr,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_chan,
  output logic [11:0] m_avg,
  output logic [7:0]  overflow_count
);

  localparam int NCH   = 10;
  localparam int ACC_W = 12 + LOG2_N;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(FIFO_DEPTH);

  logic [ACC_W-1:0]  acc_q [NCH];
  logic [ACC_W-1:0]  acc_d [NCH];
  logic [LOG2_N-1:0] cnt_q [NCH];
  logic [LOG2_N-1:0] cnt_d [NCH];

  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [15:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [7:0]        ovf_q, ovf_d;

  logic              hit;
  logic [3:0]        idx;
  logic [11:0]       sample;
  logic [ACC_W-1:0]  sum;
  logic [11:0]       result;
  logic              complete;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [15:0]       head;
  logic              unused_data_bits;

  assign sample           = s_data[15:4];
  assign unused_data_bits = ^s_data[3:0];

  always_comb begin
    hit = 1'b1;
    idx = 4'd0;
    case (s_daddr)
      7'h10:   idx = 4'd0;
      7'h11:   idx = 4'd1;
      7'h12:   idx = 4'd2;
      7'h1A:   idx = 4'd3;
      7'h13:   idx = 4'd4;
      7'h14:   idx = 4'd5;
      7'h18:   idx = 4'd6;
      7'h1B:   idx = 4'd7;
      7'h15:   idx = 4'd8;
      7'h03:   idx = 4'd9;
      default: hit = 1'b0;
    endcase
  end

  // Accumulator is wide enough for N full-scale samples, so the sum cannot wrap.
  assign sum      = acc_q[idx] + ACC_W'(sample);
  assign result   = sum[ACC_W-1:LOG2_N];
  assign complete = s_drdy & hit & (cnt_q[idx] == CNT_LAST);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (s_drdy && hit) begin
      if (complete) begin
        acc_d[idx] = '0;
        cnt_d[idx] = '0;
      end else begin
        acc_d[idx] = sum;
        cnt_d[idx] = cnt_q[idx] + 1'b1;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO only drops when the head is held.
  assign pop     = (occ_q != '0) & m_ready;
  assign push_ok = complete & ((occ_q != OCC_FULL) | pop);
  assign drop    = complete & ~push_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {idx, result};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (drop && ovf_q != 8'hFF) begin
      ovf_d = ovf_q + 8'd1;
    end
    occ_d = occ_q + OCC_W'(push_ok) - OCC_W'(pop);
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign m_valid        = (occ_q != '0);
  assign m_chan         = m_valid ? head[15:12] : 4'd0;
  assign m_avg          = m_valid ? head[11:0] : 12'd0;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_xadc_channel_averager.sv
// tb/tb_xadc_channel_averager.sv - self-checking bench for xadc_channel_averager
// Reference model: per-channel running sums plus a queue of pending results.
module tb_xadc_channel_averager;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b0;
  logic        s_drdy = 1'b0;
  logic [6:0]  s_daddr = '0;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_chan;
  logic [11:0] m_avg;
  logic [7:0]  overflow_count;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] mq[$];
  int unsigned ch_sum[10];
  int          ch_cnt[10];
  int          ovf_m;
  logic [6:0]  map_addr[10] = '{7'h10, 7'h11, 7'h12, 7'h1A, 7'h13, 7'h14, 7'h18, 7'h1B, 7'h15, 7'h03};

  xadc_channel_averager #(.LOG2_N(LOG2_N), .FIFO_DEPTH(DEPTH)) dut (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .s_drdy(s_drdy), .s_daddr(s_daddr), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_avg(m_avg),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  function automatic int chan_of(input logic [6:0] a);
    for (int i = 0; i < 10; i++) if (map_addr[i] == a) return i;
    return -1;
  endfunction

  task automatic reset_model();
    mq.delete();
    for (int i = 0; i < 10; i++) begin ch_sum[i] = 0; ch_cnt[i] = 0; end
    ovf_m = 0;
  endtask

  // One clock of stimulus; the model predicts what the edge does, then outputs are sampled 1ns later.
  task automatic step(input logic drdy, input logic [6:0] addr, input logic [15:0] data, input logic rdy);
    int ch;
    bit pop, full, done;
    logic [15:0] res;
    @(negedge clk);
    s_drdy = drdy; s_daddr = addr; s_data = data; m_ready = rdy;
    pop = rdy && (mq.size() > 0);
    full = (mq.size() == DEPTH);
    done = 0;
    res = '0;
    ch = chan_of(addr);
    if (drdy && ch >= 0) begin
      ch_sum[ch] += data[15:4];
      ch_cnt[ch]++;
      if (ch_cnt[ch] == N) begin
        res = {4'(ch), 12'(ch_sum[ch] / N)};
        ch_sum[ch] = 0;
        ch_cnt[ch] = 0;
        done = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (!full || pop) mq.push_back(res);
      else if (ovf_m < 255) ovf_m++;
    end
    @(posedge clk);
    #1;
    s_drdy = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_model();
    ck_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({m_valid, m_chan, m_avg, overflow_count} !== 25'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%0b ch=%0h avg=%0h ovf=%0d, want all 0", m_valid, m_chan, m_avg, overflow_count);
    end
    @(negedge clk);
    ck_rst = 1'b1;
  endtask

  task automatic test_single_channel();
    int vcycles = 0;
    logic [15:0] d[4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b1, 7'h10, d[i], 1'b1);
      else       step(1'b0, 7'h00, 16'h0, 1'b1);
      compared++;
      if (m_valid !== (mq.size() != 0)) begin
        mismatched++;
        $display("FAIL single_valid cyc %0d: got %0b want %0b", i, m_valid, mq.size() != 0);
      end
      if (m_valid) begin
        vcycles++;
        compared++;
        if ({m_chan, m_avg} !== 16'h0280) begin
          mismatched++;
          $display("FAIL single_result: got ch=%0h avg=%0h want ch=0 avg=280", m_chan, m_avg);
        end
      end
    end
    compared++;
    if (vcycles != 1) begin
      mismatched++;
      $display("FAIL single_valid_width: got %0d cycles want 1", vcycles);
    end
  endtask

  task automatic test_interleave();
    logic [15:0] got[$];
    for (int i = 0; i < 11; i++) begin
      if (i < 8) step(1'b1, (i % 2 == 0) ? 7'h1A : 7'h03, (i % 2 == 0) ? 16'hFFF0 : 16'h0010, 1'b1);
      else       step(1'b0, 7'h00, 16'h0, 1'b1);
      if (m_valid) got.push_back({m_chan, m_avg});
    end
    compared++;
    if (got.size() != 2 || got[0] !== 16'h3FFF || got[1] !== 16'h9001) begin
      mismatched++;
      $display("FAIL interleave: got %0d results first=%h want 2 results 3fff then 9001",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
  endtask

  task automatic test_unmapped();
    logic [15:0] got[$];
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 7'h7F, 16'($urandom), 1'b1);
      compared++;
      if (m_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL unmapped_valid: got %0b want 0", m_valid);
      end
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b1, 7'h11, 16'h8000, 1'b1);
      else       step(1'b0, 7'h00, 16'h0, 1'b1);
      if (m_valid) got.push_back({m_chan, m_avg});
    end
    compared++;
    if (got.size() != 1 || got[0] !== 16'h1800) begin
      mismatched++;
      $display("FAIL unmapped_result: got %0d results first=%h want 1 result 1800",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
    compared++;
    if (overflow_count !== 8'd0) begin
      mismatched++;
      $display("FAIL unmapped_ovf: got %0d want 0", overflow_count);
    end
  endtask

  task automatic test_overflow();
    int pops = 0;
    for (int k = 0; k < 5; k++) begin
      int c = $urandom_range(0, 9);
      for (int j = 0; j < N; j++) step(1'b1, map_addr[c], 16'($urandom), 1'b0);
    end
    compared++;
    if (m_valid !== 1'b1 || overflow_count !== 8'd1) begin
      mismatched++;
      $display("FAIL overflow_fill: got v=%0b ovf=%0d want v=1 ovf=1", m_valid, overflow_count);
    end
    for (int i = 0; i < 6; i++) begin
      if (m_valid) begin
        pops++;
        compared++;
        if ({m_chan, m_avg} !== mq[0]) begin
          mismatched++;
          $display("FAIL overflow_order pop %0d: got %h want %h", pops, {m_chan, m_avg}, mq[0]);
        end
      end
      step(1'b0, 7'h00, 16'h0, 1'b1);
    end
    compared++;
    if (pops != 4 || m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_drain: got %0d pops v=%0b want 4 pops v=0", pops, m_valid);
    end
  endtask

  task automatic test_full_pop();
    int pops = 0;
    logic [7:0] ovf_before = overflow_count;
    for (int k = 0; k < 4 * N + N - 1; k++) step(1'b1, 7'h14, 16'($urandom), 1'b0);
    step(1'b1, 7'h14, 16'($urandom), 1'b1);
    compared++;
    if (overflow_count !== ovf_before) begin
      mismatched++;
      $display("FAIL full_pop_ovf: got %0d want %0d", overflow_count, ovf_before);
    end
    for (int i = 0; i < 6; i++) begin
      if (m_valid) begin
        pops++;
        compared++;
        if ({m_chan, m_avg} !== mq[0]) begin
          mismatched++;
          $display("FAIL full_pop_order pop %0d: got %h want %h", pops, {m_chan, m_avg}, mq[0]);
        end
      end
      step(1'b0, 7'h00, 16'h0, 1'b1);
    end
    compared++;
    if (pops != 4) begin
      mismatched++;
      $display("FAIL full_pop_occupancy: got %0d entries want 4", pops);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : map_addr[$urandom_range(0, 9)];
      step(1'($urandom), a, 16'($urandom), ($urandom_range(0, 3) != 0));
      compared++;
      if (m_valid !== (mq.size() != 0)) begin
        mismatched++;
        $display("FAIL rand_valid cyc %0d: got %0b want %0b", i, m_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        compared++;
        if ({m_chan, m_avg} !== mq[0]) begin
          mismatched++;
          $display("FAIL rand_head cyc %0d: got %h want %h", i, {m_chan, m_avg}, mq[0]);
        end
      end
      compared++;
      if (overflow_count !== 8'(ovf_m)) begin
        mismatched++;
        $display("FAIL rand_ovf cyc %0d: got %0d want %0d", i, overflow_count, ovf_m);
      end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 1040; i++) step(1'b1, 7'h12, 16'($urandom), 1'b0);
    compared++;
    if (overflow_count !== 8'd255 || ovf_m != 255) begin
      mismatched++;
      $display("FAIL saturate: got %0d want 255", overflow_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got[$];
    for (int i = 0; i < 3; i++) step(1'b1, 7'h10, 16'($urandom), 1'b1);
    #2;
    ck_rst = 1'b0;
    #1;
    compared++;
    if ({m_valid, m_chan, m_avg, overflow_count} !== 25'd0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got v=%0b ch=%0h avg=%0h ovf=%0d, want all 0", m_valid, m_chan, m_avg, overflow_count);
    end
    @(negedge clk);
    ck_rst = 1'b1;
    reset_model();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1'b1, 7'h10, 16'h4000, 1'b1);
      else       step(1'b0, 7'h00, 16'h0, 1'b1);
      if (m_valid) got.push_back({m_chan, m_avg});
    end
    compared++;
    if (got.size() != 1 || got[0] !== 16'h0400) begin
      mismatched++;
      $display("FAIL reset_mid_result: got %0d results first=%h want 1 result 0400",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_interleave();
    test_unmapped();
    test_overflow();
    test_full_pop();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xadc_channel_averager.md
# xadc_channel_averager

Downstream consumer of the XADC DRP read stage: captures each completed DRP read (data, address, drdy), maps the DRP address to a Pmod channel index, and box-car averages 2^LOG2_N consecutive 12-bit samples per channel. Each finished average is pushed into a small result FIFO that drives a valid/ready output toward display or UART reporting logic. Per-channel accumulation is independent, so the upstream channel-switching logic may interleave channels freely.

## Interface
- LOG2_N, 4: log2 of samples per average; legal 1..8.
- FIFO_DEPTH, 4: result FIFO entries; power of two, 2..16.
- CLK100MHZ  in  1  system clock; DRP clock domain.
- ck_rst  in  1  reset; asynchronous assert, active-low.
- s_drdy  in  1  DRP data ready; every high cycle is one sample.
- s_daddr  in  7  DRP address the read was issued to; valid with s_drdy.
- s_data  in  16  DRP read data; the sample is s_data[15:4].
- m_valid  out  1  FIFO head holds a result.
- m_ready  in  1  consumer accepts the head when high with m_valid.
- m_chan  out  4  channel index of the head result.
- m_avg  out  12  averaged sample of the head result.
- overflow_count  out  8  results dropped because the FIFO was full; saturates at 255.

## Operation
- Address map (s_daddr -> index): 0x10->0, 0x11->1, 0x12->2, 0x1A->3, 0x13->4, 0x14->5, 0x18->6, 0x1B->7, 0x15->8, 0x03->9. Any other address is ignored: no accumulator, FIFO or counter change.
- Per channel: accumulator acc[ch], width 12+LOG2_N, never overflows; sample counter cnt[ch], width LOG2_N.
- Accepted sample, cnt[ch] < 2^LOG2_N-1: acc[ch] += sample; cnt[ch] += 1.
- Accepted sample, cnt[ch] == 2^LOG2_N-1 (Nth sample): result = (acc[ch]+sample) >> LOG2_N (truncating); push {ch, result}; acc[ch] and cnt[ch] cleared to 0.
- The push is attempted every time. If the FIFO is full and no pop happens in that cycle, the result is dropped, overflow_count increments (saturating), and acc/cnt still clear.
- FIFO: show-ahead; m_chan/m_avg reflect the head whenever m_valid=1 and are held stable while m_valid=1 and m_ready=0. A pop occurs on m_valid & m_ready.
- Simultaneous push and pop: both happen. When the FIFO is full, the pop frees a slot, so the push succeeds with no drop.
- Pointers wrap modulo FIFO_DEPTH. An occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- m_ready while m_valid=0 has no effect.

## Timing
- Reset (ck_rst=0, asynchronous): all acc/cnt = 0, FIFO empty, m_valid=0, m_chan=0, m_avg=0, overflow_count=0. Release is synchronous to CLK100MHZ. A reset mid-accumulation discards partial sums.
- Sample latency: an Nth sample at edge t makes m_valid high after edge t (visible in cycle t+1) if the FIFO was empty.
- Throughput: one sample per cycle sustained, including back-to-back samples on the same channel.
- Pop latency: the next entry, or m_valid=0, appears the cycle after the accepting edge.
- All outputs are registered or decoded directly from registers; no combinational path from s_* to m_*.

## Test plan
- LOG2_N=2, channel 0: s_daddr=0x10, s_data=0x1000,0x2000,0x3000,0x4000 on consecutive cycles, m_ready=1 -> one result m_chan=0, m_avg=0x280, m_valid high exactly one cycle.
- Interleave: LOG2_N=2, alternate 0x1A (data 0xFFF0 each) and 0x03 (data 0x0010 each), 8 samples -> results {3,0xFFF} then {9,0x001}, in completion order.
- Unmapped: 4 samples at s_daddr=0x7F, then 4 at 0x11 with 0x8000 -> exactly one result {1,0x800}; overflow_count stays 0.
- Overflow: FIFO_DEPTH=4, m_ready=0, 5 completions -> m_valid=1, 4 entries retained in order, overflow_count=1. Assert m_ready -> 4 pops, then m_valid=0.
- Full plus simultaneous pop: FIFO full, m_ready=1 in the same cycle as a completion -> no drop; overflow_count unchanged; occupancy stays 4.
- Reset mid-run: LOG2_N=2, 3 samples on 0x10, pulse ck_rst low asynchronously, then 4 samples of 0x4000 -> single result {0,0x400}; all outputs 0 during reset.
